// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, redirect-kind enum and redirect target helpers
// for the fetch front end (fetch_unit, fetch_fifo).
package fetch_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int INST_W         = 32;

  // Widest PC the target helpers support; callers zero-extend into this
  // width and truncate the result back to their own ADDR_W.
  localparam int MAX_ADDR_W     = 64;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_JMP,
    REDIR_BR
  } redir_kind_e;

  // Jump: keep the upper PC bits of pc4 above the 28-bit region, splice in
  // the 26-bit word target.
  function automatic logic [MAX_ADDR_W-1:0] jump_target(
    input logic [MAX_ADDR_W-1:0] pc4,
    input logic [25:0]           target
  );
    return {pc4[MAX_ADDR_W-1:28], target, 2'b00};
  endfunction

  // Branch: pc4 plus the sign-extended word offset scaled to bytes. The sum
  // is taken modulo 2^MAX_ADDR_W and truncated by the caller, which yields
  // the required modulo-2^ADDR_W wrap.
  function automatic logic [MAX_ADDR_W-1:0] branch_target(
    input logic [MAX_ADDR_W-1:0] pc4,
    input logic [15:0]           imm
  );
    logic [MAX_ADDR_W-1:0] offset;
    offset = {{(MAX_ADDR_W-18){imm[15]}}, imm, 2'b00};
    return pc4 + offset;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, push, pop and occupancy count.
// Used for the instruction buffer ({data, pc}) and for the request tag queue.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign out_valid = (count != '0);

  // Storage holds whatever was last written; present zero while empty.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Qualify push/pop: flush wins, pop needs data, push needs room unless a
  // pop frees an entry in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (!flush) begin
      do_pop  = pop && out_valid;
      do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; validity lives in count, and
  // out_data is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction-fetch front end. Holds the PC, issues
// word-aligned requests under a credit limit, buffers in-order responses with
// their PC tags, and squashes stale work on jump/branch redirects.
// Optional feature macro: FETCH_PERF_EN adds perf_stall_cnt/perf_squash_cnt.
// ADDR_W must lie in [30, 64]; FIFO_DEPTH must be a power of two >= 2.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_jmp,
  input  logic              redirect_br,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [25:0]       redirect_target,
  input  logic [15:0]       redirect_imm,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_squash_cnt
`endif
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W   = CNT_W + 1;
  localparam int ENTRY_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc4;
  logic [ADDR_W-1:0]  redir_addr;
  redir_kind_e        redir_kind;
  logic               redirect;
  logic               req_fire;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   outstanding_nxt;
  logic [CNT_W-1:0]   discard;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   tag_count;
  logic               tag_valid;
  logic [ADDR_W-1:0]  rsp_tag;
  logic               rsp_drop;
  logic               rsp_push;
  logic               inst_pop;
  logic [ENTRY_W-1:0] fifo_out;

  // Credit: never request more than the buffer can absorb, counting both
  // buffered entries and every response still in flight (stale or not).
  assign imem_req_valid = !rst &&
                          ((SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inst_pop       = inst_valid && inst_ready;

  // Classify the redirect; jump takes priority when both are raised.
  always_comb begin
    redir_kind = REDIR_NONE;
    if (redirect_jmp)     redir_kind = REDIR_JMP;
    else if (redirect_br) redir_kind = REDIR_BR;
  end

  assign redirect = (redir_kind != REDIR_NONE);

  // Redirect target from the resolving instruction's PC + 4.
  always_comb begin
    pc4        = redirect_pc + ADDR_W'(4);
    redir_addr = pc4;
    case (redir_kind)
      REDIR_JMP: redir_addr = ADDR_W'(jump_target(MAX_ADDR_W'(pc4), redirect_target));
      REDIR_BR:  redir_addr = ADDR_W'(branch_target(MAX_ADDR_W'(pc4), redirect_imm));
      default:   redir_addr = pc4;
    endcase
  end

  // Response disposition: anything arriving while stale responses are
  // pending, or in the redirect cycle itself, is dropped.
  assign rsp_drop        = imem_rsp_valid && (redirect || (discard != '0));
  assign rsp_push        = imem_rsp_valid && tag_valid && !rsp_drop;
  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

  // Architectural PC: redirect overrides sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= redir_addr;
    else if (req_fire) pc <= pc + ADDR_W'(4);
  end

  // In-flight and stale-response counters. outstanding counts every
  // response still owed by memory; discard counts how many of the oldest of
  // those must be dropped. On redirect every remaining in-flight response
  // (including one accepted this cycle, excluding one arriving this cycle)
  // becomes stale, so discard takes the post-cycle outstanding value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect)
        discard <= outstanding_nxt;
      else if (imem_rsp_valid && (discard != '0))
        discard <= discard - CNT_W'(1);
    end
  end

  // Tag queue: PC of each accepted request, consumed by its response. It is
  // not flushed on redirect; stale responses still retire their tags.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_rsp_valid),
    .out_valid (tag_valid),
    .out_data  (rsp_tag),
    .count     (tag_count)
  );

  // Instruction buffer: {data, pc} entries, flushed on redirect.
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (rsp_push),
    .push_data ({imem_rsp_data, rsp_tag}),
    .pop       (inst_pop),
    .out_valid (inst_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign {inst_data, inst_pc} = fifo_out;

  // Every in-flight request owns exactly one tag.
  tag_tracks_outstanding: assert property (
    @(posedge clk) disable iff (rst) tag_count == outstanding
  );

`ifdef FETCH_PERF_EN
  logic [31:0] squash_inc;

  // Entries lost this cycle: buffered entries flushed (a same-cycle pop is
  // delivered, not squashed) plus a dropped response.
  always_comb begin
    squash_inc = 32'(rsp_drop);
    if (redirect)
      squash_inc = squash_inc + 32'(fifo_count) - 32'(inst_pop);
  end

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_squash_cnt <= '0;
    end else begin
      if (!imem_req_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      perf_squash_cnt <= perf_squash_cnt + squash_inc;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
